// File: rtl/i2c_slave_byte_ctrl.sv
// I2C slave bit/byte controller: START/STOP, address match, rx/tx shifting.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample filter on SCL/SDA.
module i2c_slave_byte_ctrl #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h42,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       tx_eq8,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       counter_en,
  output logic       counter_clr,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_ready,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_WAIT_STOP
  } state_t;

  state_t     state, state_nx;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;
  logic       scl_p, sda_p;

  // Idle bus is high, so reset to 1 to avoid false edges.
  always_ff @(posedge pclk) begin
    if (preset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge pclk) begin
    if (preset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end

  // The edge-detect register doubles as the filter's hold value.
  always_comb begin
    scl_s = scl_p;
    sda_s = sda_p;
    if (scl_sync[1] == scl_hist[0] &&
        scl_sync[1] == scl_hist[1])
      scl_s = scl_sync[1];
    if (sda_sync[1] == sda_hist[0] &&
        sda_sync[1] == sda_hist[1])
      sda_s = sda_sync[1];
  end
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  logic scl_rise, scl_fall;
  logic start_c, stop_c;

  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_c  = scl_s & sda_p & ~sda_s;
  assign stop_c   = scl_s & ~sda_p & sda_s;

  logic [7:0] shift, shift_nx;
  logic [7:0] tx_shift, tx_shift_nx;
  logic       ack_q, ack_nx;
  logic       rw_nx, busy_nx, oe_nx;
  logic [7:0] rxd_nx;
  logic       en_nx, clr_nx;
  logic       rxv_nx, txr_nx;
  logic [7:0] load_byte;
  logic       count_ok;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= S_IDLE;
      shift       <= 8'h00;
      tx_shift    <= 8'h00;
      ack_q       <= 1'b0;
      rw          <= 1'b0;
      busy        <= 1'b0;
      sda_oe      <= 1'b0;
      rx_data     <= 8'h00;
      counter_en  <= 1'b0;
      counter_clr <= 1'b0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
    end else begin
      state       <= state_nx;
      shift       <= shift_nx;
      tx_shift    <= tx_shift_nx;
      ack_q       <= ack_nx;
      rw          <= rw_nx;
      busy        <= busy_nx;
      sda_oe      <= oe_nx;
      rx_data     <= rxd_nx;
      counter_en  <= en_nx;
      counter_clr <= clr_nx;
      rx_valid    <= rxv_nx;
      tx_ready    <= txr_nx;
    end
  end

  assign load_byte = tx_valid ? tx_data : TX_IDLE_BYTE;
  assign count_ok  = scl_rise & ~tx_eq8 &
                     (state inside {S_ADDR, S_RX, S_TX});

  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    tx_shift_nx = tx_shift;
    ack_nx      = ack_q;
    rw_nx       = rw;
    busy_nx     = busy;
    oe_nx       = sda_oe;
    rxd_nx      = rx_data;
    en_nx       = 1'b0;
    clr_nx      = 1'b0;
    rxv_nx      = 1'b0;
    txr_nx      = 1'b0;

    if (start_c) begin
      state_nx = S_ADDR;
      clr_nx   = 1'b1;
      oe_nx    = 1'b0;
    end else if (stop_c) begin
      state_nx = S_IDLE;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else begin
      if (count_ok) begin
        en_nx    = 1'b1;
        shift_nx = {shift[6:0], sda_s};
      end
      unique case (state)
        S_ADDR: begin
          if (scl_fall && tx_eq8) begin
            if (shift[7:1] == SLAVE_ADDR) begin
              rw_nx    = shift[0];
              oe_nx    = 1'b1;
              busy_nx  = 1'b1;
              state_nx = S_ADDR_ACK;
            end else begin
              busy_nx  = 1'b0;
              state_nx = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            clr_nx = 1'b1;
            if (rw) begin
              tx_shift_nx = load_byte;
              txr_nx      = tx_valid;
              oe_nx       = ~load_byte[7];
              state_nx    = S_TX;
            end else begin
              oe_nx    = 1'b0;
              state_nx = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_fall && tx_eq8) begin
            rxd_nx   = shift;
            rxv_nx   = 1'b1;
            oe_nx    = 1'b1;
            state_nx = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            oe_nx    = 1'b0;
            clr_nx   = 1'b1;
            state_nx = S_RX;
          end
        end
        S_TX: begin
          if (scl_fall) begin
            if (!tx_eq8) begin
              tx_shift_nx = {tx_shift[6:0], 1'b0};
              oe_nx       = ~tx_shift[6];
            end else begin
              oe_nx    = 1'b0;
              state_nx = S_TX_ACK;
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise)
            ack_nx = ~sda_s;
          if (scl_fall) begin
            if (ack_q) begin
              clr_nx      = 1'b1;
              tx_shift_nx = load_byte;
              txr_nx      = tx_valid;
              oe_nx       = ~load_byte[7];
              state_nx    = S_TX;
            end else begin
              busy_nx  = 1'b0;
              oe_nx    = 1'b0;
              state_nx = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl with a bit-counter model.
// Set I2C_SLAVE_GLITCH_FILTER_EN to also exercise the glitch filter.
module tb_i2c_slave_byte_ctrl;
  localparam int Q = 8;

  logic       pclk = 1'b0;
  logic       preset;
  logic       scl;
  logic       sda_m;
  logic       sda_w;
  logic       tx_eq8;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       counter_en;
  logic       counter_clr;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic       rw;
  logic       busy;

  always #5 pclk = ~pclk;

  assign sda_w = sda_m & ~sda_oe;

  i2c_slave_byte_ctrl dut (
    .pclk       (pclk),
    .preset     (preset),
    .scl_in     (scl),
    .sda_in     (sda_w),
    .tx_eq8     (tx_eq8),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .counter_en (counter_en),
    .counter_clr(counter_clr),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_ready   (tx_ready),
    .rw         (rw),
    .busy       (busy)
  );

  logic [3:0] bcnt = 4'd0;
  always @(posedge pclk) begin
    if (preset || counter_clr)
      bcnt <= 4'd0;
    else if (counter_en && bcnt != 4'd15)
      bcnt <= bcnt + 4'd1;
  end
  assign tx_eq8 = (bcnt == 4'd8);

  int en_cnt  = 0;
  int clr_cnt = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  int ovl_cnt = 0;
  logic [7:0] rx_log [0:3];

  always @(posedge pclk) begin
    if (counter_en) en_cnt <= en_cnt + 1;
    if (counter_clr) clr_cnt <= clr_cnt + 1;
    if (tx_ready) txr_cnt <= txr_cnt + 1;
    if (counter_en && counter_clr)
      ovl_cnt <= ovl_cnt + 1;
    if (rx_valid) begin
      rx_log[rxv_cnt[1:0]] <= rx_data;
      rxv_cnt <= rxv_cnt + 1;
    end
  end

  int   n_cmp = 0;
  int   n_err = 0;
  logic last_bit;

  task automatic clk(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clk(Q);
    scl = 1'b1;   clk(Q);
    sda_m = 1'b0; clk(Q);
    scl = 1'b0;   clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clk(Q);
    scl = 1'b1;   clk(Q);
    sda_m = 1'b1; clk(Q);
  endtask

  task automatic i2c_bit(input logic b);
    sda_m = b;  clk(Q);
    scl = 1'b1; clk(Q);
    last_bit = sda_w;
    clk(Q);
    scl = 1'b0; clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_bit(1'b1);
    ack = ~last_bit;
  endtask

  task automatic read_byte(input logic mack,
                           output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1);
      d[i] = last_bit;
    end
    i2c_bit(~mack);
  endtask

  task automatic test_reset();
    logic [14:0] v;
    preset = 1'b1;
    scl = 1'b1; sda_m = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00;
    clk(4);
    v = {counter_en, counter_clr, sda_oe, rx_data,
         rx_valid, tx_ready, rw, busy};
    n_cmp++;
    if (v !== 15'h0) begin
      $display("FAIL reset_outputs: got %h want 0", v);
      n_err++;
    end
    preset = 1'b0;
    clk(4);
  endtask

  task automatic test_addr_write();
    int e0, c0;
    logic ack;
    e0 = en_cnt; c0 = clr_cnt;
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h84;
      i2c_bit(a[i]);
    end
    sda_m = 1'b1; clk(Q);
    scl = 1'b1;   clk(Q);
    ack = ~sda_w;
    n_cmp++;
    if (sda_oe !== 1'b1 || ack !== 1'b1) begin
      $display("FAIL addr_ack: oe %b ack %b want 1 1",
               sda_oe, ack);
      n_err++;
    end
    n_cmp++;
    if (busy !== 1'b1 || rw !== 1'b0) begin
      $display("FAIL addr_busy_rw: got %b%b want 10",
               busy, rw);
      n_err++;
    end
    n_cmp++;
    if (en_cnt - e0 !== 8) begin
      $display("FAIL addr_en_count: got %0d want 8",
               en_cnt - e0);
      n_err++;
    end
    clk(Q);
    scl = 1'b0; clk(Q);
    n_cmp++;
    if (clr_cnt - c0 !== 2) begin
      $display("FAIL addr_clr_count: got %0d want 2",
               clr_cnt - c0);
      n_err++;
    end
    n_cmp++;
    if (sda_oe !== 1'b0) begin
      $display("FAIL addr_release: oe %b want 0", sda_oe);
      n_err++;
    end
    i2c_stop();
    n_cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL addr_stop_busy: got %b want 0", busy);
      n_err++;
    end
  endtask

  task automatic test_mismatch();
    int   e0, r0;
    logic ack;
    r0 = rxv_cnt;
    i2c_start();
    send_byte(8'h86, ack);
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL mis_ack: ack %b busy %b want 0 0",
               ack, busy);
      n_err++;
    end
    e0 = en_cnt;
    send_byte(8'hA5, ack);
    n_cmp++;
    if (ack !== 1'b0) begin
      $display("FAIL mis_data_ack: got %b want 0", ack);
      n_err++;
    end
    n_cmp++;
    if (en_cnt - e0 !== 0) begin
      $display("FAIL mis_en: got %0d want 0", en_cnt - e0);
      n_err++;
    end
    n_cmp++;
    if (rxv_cnt - r0 !== 0) begin
      $display("FAIL mis_rxv: got %0d want 0",
               rxv_cnt - r0);
      n_err++;
    end
    i2c_stop();
  endtask

  task automatic test_write_data();
    int         r0;
    logic       a0, a1, a2;
    logic [1:0] i0, i1;
    r0 = rxv_cnt;
    i0 = r0[1:0];
    i1 = i0 + 2'd1;
    i2c_start();
    send_byte(8'h84, a0);
    send_byte(8'hA5, a1);
    send_byte(8'h3C, a2);
    n_cmp++;
    if ({a0, a1, a2} !== 3'b111) begin
      $display("FAIL wr_acks: got %b want 111",
               {a0, a1, a2});
      n_err++;
    end
    n_cmp++;
    if (rxv_cnt - r0 !== 2) begin
      $display("FAIL wr_rxv_count: got %0d want 2",
               rxv_cnt - r0);
      n_err++;
    end
    n_cmp++;
    if (rx_log[i0] !== 8'hA5) begin
      $display("FAIL wr_byte0: got %h want a5", rx_log[i0]);
      n_err++;
    end
    n_cmp++;
    if (rx_log[i1] !== 8'h3C) begin
      $display("FAIL wr_byte1: got %h want 3c", rx_log[i1]);
      n_err++;
    end
    n_cmp++;
    if (rx_data !== 8'h3C) begin
      $display("FAIL wr_rx_data: got %h want 3c", rx_data);
      n_err++;
    end
    i2c_stop();
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      $display("FAIL wr_stop: busy %b oe %b want 0 0",
               busy, sda_oe);
      n_err++;
    end
  endtask

  task automatic test_read();
    int         t0, e0;
    logic       ack;
    logic [7:0] d;
    tx_data = 8'h5A; tx_valid = 1'b1;
    t0 = txr_cnt;
    i2c_start();
    send_byte(8'h85, ack);
    n_cmp++;
    if (ack !== 1'b1 || rw !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL rd_addr: ack %b rw %b busy %b want 111",
               ack, rw, busy);
      n_err++;
    end
    n_cmp++;
    if (txr_cnt - t0 !== 1) begin
      $display("FAIL rd_ready0: got %0d want 1",
               txr_cnt - t0);
      n_err++;
    end
    tx_data = 8'h3C;
    read_byte(1'b1, d);
    n_cmp++;
    if (d !== 8'h5A) begin
      $display("FAIL rd_byte0: got %h want 5a", d);
      n_err++;
    end
    read_byte(1'b0, d);
    n_cmp++;
    if (d !== 8'h3C) begin
      $display("FAIL rd_byte1: got %h want 3c", d);
      n_err++;
    end
    n_cmp++;
    if (txr_cnt - t0 !== 2) begin
      $display("FAIL rd_ready_total: got %0d want 2",
               txr_cnt - t0);
      n_err++;
    end
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      $display("FAIL rd_nack: busy %b oe %b want 0 0",
               busy, sda_oe);
      n_err++;
    end
    e0 = en_cnt;
    send_byte(8'h84, ack);
    n_cmp++;
    if (ack !== 1'b0 || en_cnt - e0 !== 0) begin
      $display("FAIL rd_wait_stop: ack %b en %0d want 0 0",
               ack, en_cnt - e0);
      n_err++;
    end
    i2c_stop();
    tx_valid = 1'b0;
  endtask

  task automatic test_rep_start();
    int   t0, c0, e0;
    logic ack;
    tx_valid = 1'b0;
    i2c_start();
    send_byte(8'h85, ack);
    t0 = txr_cnt;
    i2c_bit(1'b1);
    i2c_bit(1'b1);
    c0 = clr_cnt;
    i2c_start();
    n_cmp++;
    if (clr_cnt - c0 !== 1) begin
      $display("FAIL rs_clr: got %0d want 1", clr_cnt - c0);
      n_err++;
    end
    n_cmp++;
    if (busy !== 1'b1 || sda_oe !== 1'b0) begin
      $display("FAIL rs_state: busy %b oe %b want 1 0",
               busy, sda_oe);
      n_err++;
    end
    i2c_stop();
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      $display("FAIL rs_stop: busy %b oe %b want 0 0",
               busy, sda_oe);
      n_err++;
    end
    n_cmp++;
    if (txr_cnt - t0 !== 0) begin
      $display("FAIL rs_no_ready: got %0d want 0",
               txr_cnt - t0);
      n_err++;
    end
    e0 = en_cnt;
    send_byte(8'h84, ack);
    n_cmp++;
    if (ack !== 1'b0 || en_cnt - e0 !== 0) begin
      $display("FAIL rs_idle: ack %b en %0d want 0 0",
               ack, en_cnt - e0);
      n_err++;
    end
    i2c_stop();
  endtask

  task automatic test_reset_mid();
    int          e0;
    logic        ack;
    logic [7:0]  a;
    logic [14:0] v;
    a = 8'h84;
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(a[i]);
    sda_m = 1'b1; clk(Q);
    scl = 1'b1;   clk(Q);
    n_cmp++;
    if (sda_oe !== 1'b1) begin
      $display("FAIL rm_pre_oe: got %b want 1", sda_oe);
      n_err++;
    end
    preset = 1'b1; clk(2);
    preset = 1'b0;
    v = {counter_en, counter_clr, sda_oe, rx_data,
         rx_valid, tx_ready, rw, busy};
    n_cmp++;
    if (v !== 15'h0) begin
      $display("FAIL rm_outputs: got %h want 0", v);
      n_err++;
    end
    clk(Q);
    scl = 1'b0; clk(Q);
    e0 = en_cnt;
    send_byte(8'h84, ack);
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rm_ignore: ack %b busy %b want 0 0",
               ack, busy);
      n_err++;
    end
    n_cmp++;
    if (en_cnt - e0 !== 0) begin
      $display("FAIL rm_en: got %0d want 0", en_cnt - e0);
      n_err++;
    end
    i2c_stop();
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    int e0;
    i2c_start();
    e0 = en_cnt;
    scl = 1'b1; clk(2);
    scl = 1'b0; clk(Q);
    n_cmp++;
    if (en_cnt - e0 !== 0) begin
      $display("FAIL glitch_en: got %0d want 0",
               en_cnt - e0);
      n_err++;
    end
    i2c_stop();
  endtask
`endif

  task automatic test_no_overlap();
    n_cmp++;
    if (ovl_cnt !== 0) begin
      $display("FAIL en_clr_overlap: got %0d want 0",
               ovl_cnt);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_mismatch();
    test_write_data();
    test_read();
    test_rep_start();
    test_reset_mid();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
